// File: rtl/npu_tile_loader.sv
// Tile loader: streams SIZE*SIZE weight words, then SIZE activation words, from a host
// valid/ready stream into the NPU datapath. Every datapath output is registered.
`timescale 1ns/1ps

module npu_tile_loader #(
    parameter int unsigned SIZE  = 4,
    parameter int unsigned NBITS = 8
) (
    input  logic                    clk,
    input  logic                    rst,
    input  logic                    start_i,
    input  logic                    in_val_i,
    input  logic [NBITS-1:0]        in_data_i,
    output logic                    in_rdy_o,
    input  logic                    load_rdy_i,
    output logic [NBITS-1:0]        w_in_o,
    output logic                    w_load_val_o,
    output logic [$clog2(SIZE)-1:0] w_load_sel_o,
    output logic [NBITS-1:0]        x_in_o,
    output logic                    x_load_val_o,
    output logic                    busy_o,
    output logic                    done_o
);

    localparam int unsigned SelW = $clog2(SIZE);
    localparam int unsigned CntW = $clog2(SIZE * SIZE);

    typedef enum logic [1:0] {StIdle, StLoadW, StLoadX, StDone} state_e;

    state_e            state_q;
    logic [CntW-1:0]   cnt_q;
    logic [NBITS-1:0]  w_in_q;
    logic [NBITS-1:0]  x_in_q;
    logic [SelW-1:0]   w_sel_q;
    logic              w_val_q;
    logic              x_val_q;
    logic              busy_q;
    logic              done_q;
    logic              xfer;

    // Ready is combinational so the host sees downstream back-pressure in the same cycle.
    assign in_rdy_o = ((state_q == StLoadW) || (state_q == StLoadX)) && load_rdy_i;
    assign xfer     = in_rdy_o && in_val_i;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q <= StIdle;
            cnt_q   <= '0;
            w_in_q  <= '0;
            x_in_q  <= '0;
            w_sel_q <= '0;
            w_val_q <= 1'b0;
            x_val_q <= 1'b0;
            busy_q  <= 1'b0;
            done_q  <= 1'b0;
        end else begin
            w_val_q <= 1'b0;
            x_val_q <= 1'b0;
            done_q  <= 1'b0;
            unique case (state_q)
                StIdle: begin
                    if (start_i) begin
                        state_q <= StLoadW;
                        cnt_q   <= '0;
                        busy_q  <= 1'b1;
                    end
                end
                StLoadW: begin
                    if (xfer) begin
                        w_in_q  <= in_data_i;
                        w_sel_q <= cnt_q[SelW-1:0];
                        w_val_q <= 1'b1;
                        if (cnt_q == CntW'(SIZE * SIZE - 1)) begin
                            state_q <= StLoadX;
                            cnt_q   <= '0;
                        end else begin
                            cnt_q <= cnt_q + 1'b1;
                        end
                    end
                end
                StLoadX: begin
                    if (xfer) begin
                        x_in_q  <= in_data_i;
                        x_val_q <= 1'b1;
                        if (cnt_q == CntW'(SIZE - 1)) begin
                            state_q <= StDone;
                            cnt_q   <= '0;
                            done_q  <= 1'b1;
                        end else begin
                            cnt_q <= cnt_q + 1'b1;
                        end
                    end
                end
                StDone: begin
                    state_q <= StIdle;
                    busy_q  <= 1'b0;
                end
                default: begin
                    state_q <= StIdle;
                    busy_q  <= 1'b0;
                end
            endcase
        end
    end

    assign w_in_o       = w_in_q;
    assign w_load_val_o = w_val_q;
    assign w_load_sel_o = w_sel_q;
    assign x_in_o       = x_in_q;
    assign x_load_val_o = x_val_q;
    assign busy_o       = busy_q;
    assign done_o       = done_q;

endmodule

// File: tb/tb_npu_tile_loader.sv
// Directed bench for npu_tile_loader (SIZE=4): full tiles with bubbles, stalls,
// ignored starts and a mid-tile asynchronous reset.
`timescale 1ns/1ps

module tb_npu_tile_loader;

    localparam int SIZE  = 4;
    localparam int NBITS = 8;

    logic             clk = 1'b0;
    logic             rst;
    logic             start;
    logic             in_val;
    logic [NBITS-1:0] in_data;
    logic             in_rdy;
    logic             load_rdy;
    logic [NBITS-1:0] w_in;
    logic             w_load_val;
    logic [1:0]       w_load_sel;
    logic [NBITS-1:0] x_in;
    logic             x_load_val;
    logic             busy;
    logic             done;

    int passed = 0;
    int total  = 0;
    int w_seen = 0;
    int x_seen = 0;
    int done_seen = 0;
    logic [NBITS-1:0] last_w = '0;
    logic [NBITS-1:0] last_x = '0;

    npu_tile_loader #(.SIZE(SIZE), .NBITS(NBITS)) dut (
        .clk          (clk),
        .rst          (rst),
        .start_i      (start),
        .in_val_i     (in_val),
        .in_data_i    (in_data),
        .in_rdy_o     (in_rdy),
        .load_rdy_i   (load_rdy),
        .w_in_o       (w_in),
        .w_load_val_o (w_load_val),
        .w_load_sel_o (w_load_sel),
        .x_in_o       (x_in),
        .x_load_val_o (x_load_val),
        .busy_o       (busy),
        .done_o       (done)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        total++;
        assert (obs === exp) passed++;
        else $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
    endtask

    always @(negedge clk) begin
        if (!rst) begin
            check("valid_exclusive", 32'(w_load_val & x_load_val), 32'd0);
            if (w_load_val) w_seen++;
            if (x_load_val) x_seen++;
            if (done) done_seen++;
        end
    end

    task automatic start_tile();
        start = 1'b1;
        @(posedge clk); #1;
        start = 1'b0;
        check("busy_after_start", 32'(busy), 32'd1);
    endtask

    // Drive words 1..stop_at; expectations come from the bench's own view of each accept.
    task automatic stream(input int stop_at, input bit gaps, input int stall_at,
                          input int stall_len, input bit start_in_x);
        int idx = 0;
        int cyc = 0;
        int stalls = stall_len;
        bit acc;
        while (idx < stop_at && cyc < 400) begin
            in_val   = gaps ? (cyc % 2 == 0) : 1'b1;
            load_rdy = !(idx == stall_at && stalls > 0);
            if (!load_rdy) stalls--;
            in_data  = NBITS'(idx + 1);
            start    = start_in_x && (idx >= SIZE * SIZE);
            #1;
            check("in_rdy", 32'(in_rdy), 32'(load_rdy));
            acc = in_val && load_rdy;
            @(posedge clk); #1;
            check("w_load_val", 32'(w_load_val), 32'(acc && idx < SIZE * SIZE));
            check("x_load_val", 32'(x_load_val), 32'(acc && idx >= SIZE * SIZE));
            if (acc && idx < SIZE * SIZE) begin
                last_w = NBITS'(idx + 1);
                check("w_load_sel", 32'(w_load_sel), 32'(idx % SIZE));
            end
            if (acc && idx >= SIZE * SIZE) last_x = NBITS'(idx + 1);
            check("w_in", 32'(w_in), 32'(last_w));
            check("x_in", 32'(x_in), 32'(last_x));
            if (acc) idx++;
            cyc++;
        end
        in_val   = 1'b0;
        start    = 1'b0;
        load_rdy = 1'b1;
        check("stream_budget", 32'(idx), 32'(stop_at));
    endtask

    task automatic full_tile(input bit gaps, input int stall_at, input int stall_len,
                             input bit start_late);
        int w0 = w_seen;
        int x0 = x_seen;
        int d0 = done_seen;
        start_tile();
        stream(SIZE * SIZE + SIZE, gaps, stall_at, stall_len, start_late);
        check("done_pulse", 32'(done), 32'd1);
        check("busy_in_done", 32'(busy), 32'd1);
        check("in_rdy_in_done", 32'(in_rdy), 32'd0);
        if (start_late) start = 1'b1;
        @(posedge clk); #1;
        start = 1'b0;
        check("done_cleared", 32'(done), 32'd0);
        check("busy_idle", 32'(busy), 32'd0);
        check("in_rdy_idle", 32'(in_rdy), 32'd0);
        @(posedge clk); #1;
        check("still_idle", 32'(busy), 32'd0);
        check("w_count", 32'(w_seen - w0), 32'd16);
        check("x_count", 32'(x_seen - x0), 32'd4);
        check("done_count", 32'(done_seen - d0), 32'd1);
    endtask

    task automatic check_all_zero(input string tag);
        check({tag, "_in_rdy"}, 32'(in_rdy), 32'd0);
        check({tag, "_busy"}, 32'(busy), 32'd0);
        check({tag, "_done"}, 32'(done), 32'd0);
        check({tag, "_w_val"}, 32'(w_load_val), 32'd0);
        check({tag, "_x_val"}, 32'(x_load_val), 32'd0);
        check({tag, "_w_in"}, 32'(w_in), 32'd0);
        check({tag, "_x_in"}, 32'(x_in), 32'd0);
        check({tag, "_w_sel"}, 32'(w_load_sel), 32'd0);
    endtask

    initial begin
        int d0;
        rst      = 1'b1;
        start    = 1'b0;
        in_val   = 1'b0;
        in_data  = '0;
        load_rdy = 1'b1;
        repeat (2) @(posedge clk);
        #1;
        check_all_zero("reset");
        @(negedge clk);
        rst = 1'b0;
        @(posedge clk); #1;
        check("idle_after_reset", 32'(busy), 32'd0);

        // Data offered in IDLE must not be taken.
        in_val  = 1'b1;
        in_data = 8'hAA;
        #1;
        check("idle_no_rdy", 32'(in_rdy), 32'd0);
        @(posedge clk); #1;
        check("idle_no_fwd", 32'(w_load_val), 32'd0);
        in_val = 1'b0;

        full_tile(1'b0, -1, 0, 1'b0);   // continuous stream
        full_tile(1'b1, -1, 0, 1'b0);   // in_val toggling every cycle
        full_tile(1'b0, 5, 3, 1'b0);    // load_rdy low 3 cycles at the 6th weight
        full_tile(1'b0, -1, 0, 1'b1);   // start pulsed in LOAD_X and DONE
        full_tile(1'b0, -1, 0, 1'b0);   // normal tile after the ignored starts

        // Asynchronous reset after the 9th weight, well away from a clock edge.
        d0 = done_seen;
        start_tile();
        stream(9, 1'b0, -1, 0, 1'b0);
        check("pre_reset_w_in", 32'(w_in), 32'd9);
        #2;
        rst = 1'b1;
        #1;
        check_all_zero("async_reset");
        last_w = '0;
        last_x = '0;
        @(negedge clk); #1;
        rst = 1'b0;
        check("no_done_on_abort", 32'(done_seen - d0), 32'd0);
        full_tile(1'b0, -1, 0, 1'b0);

        $display("%0d/%0d checks passed", passed, total);
        $finish;
    end

endmodule
